// File: rtl/voice_frame_declick_if.sv
// Valid/ready sample stream between audio pipeline stages.
// The producer drives valid/data, the consumer drives ready.
interface voice_frame_declick_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/voice_frame_declick.sv
// Frame-boundary declicker: decays the step between frames over XFADE_LEN samples.
// Optional click statistics counter enabled by VOICE_DECLICK_STATS_EN.
module voice_frame_declick #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_LEN   = 600,
  parameter int XFADE_SHIFT = 4,
  parameter int XFADE_LEN   = 1 << XFADE_SHIFT
`ifdef VOICE_DECLICK_STATS_EN
  , parameter int CLICK_THRESH = 2048
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic bypass,
  voice_frame_declick_if.slave  src,
  voice_frame_declick_if.master dst,
  output logic out_frame_start
`ifdef VOICE_DECLICK_STATS_EN
  , output logic [15:0] click_count
`endif
);

  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int KW = XFADE_SHIFT + 1;
  localparam int OW = DATA_WIDTH + 1;
  localparam int PW = DATA_WIDTH + XFADE_SHIFT + 2;

  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(XFADE_LEN - 1);
  localparam logic [KW-1:0] K_LEN    = KW'(XFADE_LEN);

  localparam logic signed [PW-1:0] S_MAX =
    PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] S_MIN =
    PW'(-(1 << (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {
    ST_FIRST,
    ST_PASS,
    ST_XFADE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]         idx_q;
  logic [KW-1:0]         k_q;
  logic signed [OW-1:0]  off_q;
  logic signed [OW-1:0]  off_new;
  logic signed [OW-1:0]  off_cur;
  logic [DATA_WIDTH-1:0] last_q;
  logic                  have_prev;
  logic                  rdy_en;

  logic                  xfer;
  logic                  frame0;
  logic                  start_xf;
  logic                  apply;
  logic [KW-1:0]         k_cur;
  logic [KW-1:0]         gain;
  logic signed [PW-1:0]  off_x;
  logic signed [PW-1:0]  gain_x;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  shifted;
  logic signed [PW-1:0]  step;
  logic signed [PW-1:0]  din_x;
  logic signed [PW-1:0]  sum;
  logic [DATA_WIDTH-1:0] res;

  // rdy_en keeps the input closed while reset is held
  assign src.ready = rdy_en && (!dst.valid || dst.ready);
  assign xfer      = src.valid && src.ready;
  assign frame0    = (idx_q == '0);

  assign off_new = {last_q[DATA_WIDTH-1], last_q}
                 - {src.data[DATA_WIDTH-1], src.data};

  assign start_xf = xfer && frame0 && have_prev
                 && !bypass && (state_q == ST_PASS);
  assign apply    = start_xf || (state_q == ST_XFADE);

  // the boundary sample itself is the k==0 point of the decay
  assign off_cur = start_xf ? off_new : off_q;
  assign k_cur   = start_xf ? '0 : k_q;
  assign gain    = K_LEN - k_cur;

  assign off_x   = {{(PW-OW){off_cur[OW-1]}}, off_cur};
  assign gain_x  = {{(PW-KW){1'b0}}, gain};
  assign prod    = off_x * gain_x;
  assign shifted = prod >>> XFADE_SHIFT;
  assign step    = apply ? shifted : '0;
  assign din_x   = {{(PW-DATA_WIDTH){src.data[DATA_WIDTH-1]}}, src.data};
  assign sum     = din_x + step;

  always_comb begin
    res = sum[DATA_WIDTH-1:0];
    unique case (1'b1)
      (sum > S_MAX): res = S_MAX[DATA_WIDTH-1:0];
      (sum < S_MIN): res = S_MIN[DATA_WIDTH-1:0];
      default:       res = sum[DATA_WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FIRST:
        if (xfer && idx_q == IDX_LAST) state_d = ST_PASS;
      ST_PASS:
        if (start_xf && XFADE_LEN > 1) state_d = ST_XFADE;
      ST_XFADE:
        if (xfer && k_q == K_LAST) state_d = ST_PASS;
      default:
        state_d = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_FIRST;
      idx_q           <= '0;
      k_q             <= '0;
      off_q           <= '0;
      last_q          <= '0;
      have_prev       <= 1'b0;
      rdy_en          <= 1'b0;
      dst.valid       <= 1'b0;
      dst.data        <= '0;
      out_frame_start <= 1'b0;
    end else begin
      rdy_en  <= 1'b1;
      state_q <= state_d;
      if (xfer) begin
        idx_q           <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        dst.valid       <= 1'b1;
        dst.data        <= res;
        out_frame_start <= frame0;
        if (idx_q == IDX_LAST) begin
          last_q    <= res;
          have_prev <= 1'b1;
        end
        if (start_xf) begin
          off_q <= off_new;
          k_q   <= KW'(1);
        end else if (state_q == ST_XFADE) begin
          k_q <= k_q + KW'(1);
        end
      end else if (dst.ready) begin
        dst.valid       <= 1'b0;
        out_frame_start <= 1'b0;
      end
    end
  end

`ifdef VOICE_DECLICK_STATS_EN
  logic [OW-1:0] mag;

  assign mag = off_new[OW-1] ? OW'(-off_new) : OW'(off_new);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      click_count <= '0;
    end else if (start_xf && mag >= OW'(CLICK_THRESH)
                 && click_count != 16'hFFFF) begin
      click_count <= click_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/voice_frame_declick.md
Name: voice_frame_declick

Overview:
- Downstream stage of the real-time pitch-shift block. It consumes that block's output stream, which is concatenated FRAME_LEN-sample processed frames.
- At each frame boundary it removes the step discontinuity ("click") by adding a decaying offset over the first XFADE_LEN samples of the new frame.
- Streaming valid/ready in and out, one register stage; the output feeds the audio-out FIFO.

Parameters:
- DATA_WIDTH, 16, sample width, signed two's complement.
- FRAME_LEN, 600, samples per frame; the frame counter wraps at this value.
- XFADE_SHIFT, 4, log2 of decay length.
- XFADE_LEN, 1<<XFADE_SHIFT, samples over which the offset decays; must be less than FRAME_LEN.
- CLICK_THRESH, 2048, magnitude threshold for the click counter (optional feature only).

Ports:
- clk  in  1  processing clock.
- rst  in  1  asynchronous reset, active-high.
- bypass  in  1  1 = pass samples unmodified; sampled at frame start.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_WIDTH  input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_WIDTH  corrected sample.
- out_frame_start  out  1  high with the first output sample of each frame.
- click_count  out  16  only present with VOICE_DECLICK_STATS_EN.

Behaviour:
- Reset (async, rst=1): all outputs 0 (in_ready 0 during reset, 1 from the first cycle after release), counters 0, have_prev=0, state ST_FIRST.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Input transfer on in_valid && in_ready; result registered into out_data/out_valid on that edge, so latency is 1 cycle.
  - out_valid stays high and out_data stays stable until out_ready. Full throughput of 1 sample/cycle.
- Counters advance only on input transfer:
  - idx: 0..FRAME_LEN-1, wraps to 0.
  - k: position within decay, 0..XFADE_LEN.
- Frame start is idx==0. out_frame_start is registered with that sample.
- last_out register holds the last *output* sample of the frame (idx==FRAME_LEN-1); have_prev is set at that point.
- States:
  - ST_FIRST: first frame after reset. Pass-through. On idx==FRAME_LEN-1 transfer, go to ST_PASS.
  - ST_PASS: pass-through. On a transfer with idx==0 and have_prev:
    - if bypass==0: capture offset = last_out - in_data (DATA_WIDTH+1 bits, signed, no overflow), set k=0, go to ST_XFADE;
    - if bypass==1: latch bypass for the whole frame and stay in ST_PASS.
  - ST_XFADE: out = sat(in_data + ((offset*(XFADE_LEN-k)) >>> XFADE_SHIFT)).
    - Product is DATA_WIDTH+XFADE_SHIFT+2 bits signed; arithmetic shift floors toward -inf.
    - k increments per transfer; after the k==XFADE_LEN-1 sample, go to ST_PASS.
    - k==0 gives out = last_out exactly.
- Saturation: clamp the sum to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Boundary cases:
  - Stall (out_valid && !out_ready): no state, counter or offset change; input is not accepted.
  - bypass changes mid-frame: ignored until the next idx==0.
  - rst mid-frame: immediate return to ST_FIRST; the in-flight output is discarded and have_prev is cleared.
  - Frame ends during ST_XFADE: impossible since XFADE_LEN < FRAME_LEN.

Optional Feature:
- Macro VOICE_DECLICK_STATS_EN.
- Defined: click_count port exists. It counts frame boundaries in ST_PASS→ST_XFADE where |offset| >= CLICK_THRESH, saturating at 65535, reset to 0. Bypassed frames are not counted.
- Undefined: port and counter logic absent; all other behaviour is identical.

Test Plan:
- Frame 1 all 1000, frame 2 all 0, out_ready=1 → frame 2 outputs 1000, 937, 875, ... 62 at k=15, then 0 from sample 16. out_frame_start high on samples 0 and 600.
- First frame after reset starts with 5000 → output 5000, no decay applied, click_count unchanged.
- Frame 1 last sample 32000, frame 2 = 0 then 32767, ... → sample 1 saturates to 32767; sample 0 = 32000.
- bypass=1 asserted before frame 2 with the same data as the first scenario → frame 2 outputs all 0; toggling bypass mid-frame has no effect.
- Random out_ready backpressure (50%) over 3 frames → output sequence bit-identical to the no-stall run; no sample lost or duplicated; out_data stable while stalled.
- rst pulse at idx 300 of frame 2, then new frames → next frame treated as ST_FIRST (no decay). With VOICE_DECLICK_STATS_EN, the first scenario gives click_count=0 (1000 < 2048), and a 0→3000 step gives 1.
